mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter_pkg.sv | 86 ++++++++
 rtl/bus_grant_sel.sv | 37 +++
 rtl/mem_bus_arbiter.sv | 102 ++++++++++
 tb/tb_mem_bus_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared CPU bus definitions: fetch/data/memory payload structs, arbiter state and source enums,
// and helpers that turn an upstream request into a memory-port request.
package mem_bus_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 3;
  localparam int unsigned STRB_W = 4;

  localparam logic [SIZE_W-1:0] SIZE_WORD = SIZE_W'(3'b010);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [SIZE_W-1:0] size;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic              valid;
    logic              is_write;
    logic [ADDR_W-1:0] addr;
    logic [SIZE_W-1:0] size;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] data;
  } mem_req_t;

  typedef struct packed {
    logic              ready;
    logic              last;
    logic [DATA_W-1:0] data;
  } mem_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } bus_src_e;

  // Fetches are always full-word reads.
  function automatic mem_req_t from_ibus(input ibus_req_t r);
    mem_req_t m;
    m.valid    = r.valid;
    m.is_write = 1'b0;
    m.addr     = r.addr;
    m.size     = SIZE_WORD;
    m.strobe   = '0;
    m.data     = '0;
    return m;
  endfunction

  function automatic mem_req_t from_dbus(input dbus_req_t r);
    mem_req_t m;
    m.valid    = r.valid;
    m.is_write = |r.strobe;
    m.addr     = r.addr;
    m.size     = r.size;
    m.strobe   = r.strobe;
    m.data     = r.data;
    return m;
  endfunction

endpackage

// File: rtl/bus_grant_sel.sv
// Fetch/data arbitration with a saturating starvation counter that eventually forces a fetch grant.
module bus_grant_sel
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_en,
  input  logic i_ivalid,
  input  logic i_dvalid,
  output logic o_grant_i_c,
  output logic o_grant_d_c
);

  localparam int unsigned CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_force_i;

  assign w_force_i   = (32'(r_starve_cnt) == STARVE_LIMIT);
  assign o_grant_i_c = i_en && i_ivalid && (!i_dvalid || w_force_i);
  assign o_grant_d_c = i_en && i_dvalid && !o_grant_i_c;

  // Counts consecutive grants where a waiting fetch lost to data.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_starve_cnt <= '0;
    end else if (o_grant_i_c) begin
      r_starve_cnt <= '0;
    end else if (o_grant_d_c && i_ivalid && (r_starve_cnt != CNT_MAX)) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the fetch and data buses, one transaction at a time.
// Handshake pulses are combinational so grant and data return land in the cycle they occur.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output mem_req_t   mreq,
  input  mem_resp_t  mresp
);

  arb_state_e r_state;
  arb_state_e w_state_next;
  mem_req_t   r_buf;
  bus_src_e   r_src;
  logic       w_arb_en;
  logic       w_grant_i;
  logic       w_grant_d;

  assign w_arb_en = resetn && (r_state == ST_IDLE);

  bus_grant_sel #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant_sel (
    .clk        (clk),
    .resetn     (resetn),
    .i_en       (w_arb_en),
    .i_ivalid   (ireq.valid),
    .i_dvalid   (dreq.valid),
    .o_grant_i_c(w_grant_i),
    .o_grant_d_c(w_grant_d)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_grant_i || w_grant_d) w_state_next = ST_REQ;
      ST_REQ:  if (mresp.ready) w_state_next = ST_WAIT;
      ST_WAIT: if (mresp.last) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Request snapshot taken at grant; the memory port only ever sees this copy.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_buf <= '0;
      r_src <= SRC_I;
    end else if (w_grant_d) begin
      r_buf <= from_dbus(dreq);
      r_src <= SRC_D;
    end else if (w_grant_i) begin
      r_buf <= from_ibus(ireq);
      r_src <= SRC_I;
    end
  end

  always_comb begin
    iresp = '0;
    dresp = '0;
    mreq  = '0;
    if (resetn) begin
      case (r_state)
        ST_IDLE: begin
          iresp.addr_ok = w_grant_i;
          dresp.addr_ok = w_grant_d;
        end
        ST_REQ: begin
          mreq       = r_buf;
          mreq.valid = 1'b1;
        end
        ST_WAIT: begin
          if (mresp.last) begin
            if (r_src == SRC_D) begin
              dresp.data_ok = 1'b1;
              dresp.data    = mresp.data;
            end else begin
              iresp.data_ok = 1'b1;
              iresp.data    = mresp.data;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus random traffic against a
// transaction-level model of grant order, memory-port contents and response routing.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int unsigned LIMIT = 3;

  logic       clk = 1'b0;
  logic       resetn;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  mem_req_t   mreq;
  mem_resp_t  mresp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .resetn(resetn),
    .ireq  (ireq),
    .iresp (iresp),
    .dreq  (dreq),
    .dresp (dresp),
    .mreq  (mreq),
    .mresp (mresp)
  );

  task automatic idle_inputs();
    ireq  = '0;
    dreq  = '0;
    mresp = '0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    repeat (3) begin
      @(negedge clk); #1;
      n_checks++; if (mreq !== '0) begin n_fail++; $display("FAIL rst_mreq got=%h exp=0", mreq); end
      n_checks++; if (iresp !== '0) begin n_fail++; $display("FAIL rst_iresp got=%h exp=0", iresp); end
      n_checks++; if (dresp !== '0) begin n_fail++; $display("FAIL rst_dresp got=%h exp=0", dresp); end
    end
    @(negedge clk); resetn = 1'b1; #1;
    n_checks++; if ((mreq !== '0) || (iresp !== '0) || (dresp !== '0)) begin
      n_fail++; $display("FAIL post_rst_outputs got mreq=%h iresp=%h dresp=%h exp=0", mreq, iresp, dresp);
    end
    // Get into REQ, then reset for three cycles.
    @(negedge clk); ireq.valid = 1'b1; ireq.addr = 32'h1234_5670; #1;
    n_checks++; if (iresp.addr_ok !== 1'b1) begin n_fail++; $display("FAIL rstmid_grant got=%b exp=1", iresp.addr_ok); end
    @(negedge clk); ireq.valid = 1'b0; #1;
    n_checks++; if (mreq.valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_req got=%b exp=1", mreq.valid); end
    resetn = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      mresp.ready = 1'b1; mresp.last = (c == 2); mresp.data = $urandom; #1;
      n_checks++; if (mreq.valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_mreq c=%0d got=%b exp=0", c, mreq.valid); end
      n_checks++; if ({iresp.data_ok, dresp.data_ok} !== 2'b00) begin
        n_fail++; $display("FAIL rstmid_data_ok c=%0d got=%b%b exp=00", c, iresp.data_ok, dresp.data_ok);
      end
    end
    // Stale response after reset must be ignored.
    @(negedge clk); resetn = 1'b1; mresp.ready = 1'b1; mresp.last = 1'b1; #1;
    n_checks++; if ({iresp.data_ok, dresp.data_ok, mreq.valid} !== 3'b000) begin
      n_fail++; $display("FAIL stale_resp got=%b%b%b exp=000", iresp.data_ok, dresp.data_ok, mreq.valid);
    end
    @(negedge clk); mresp = '0; ireq.valid = 1'b1; ireq.addr = 32'h0000_0040; #1;
    n_checks++; if (iresp.addr_ok !== 1'b1) begin n_fail++; $display("FAIL rst_back_idle got=%b exp=1", iresp.addr_ok); end
    @(negedge clk); ireq.valid = 1'b0; mresp.ready = 1'b1; #1;
    @(negedge clk); mresp.ready = 1'b0; mresp.last = 1'b1; mresp.data = 32'hA5A5_0001; #1;
    n_checks++; if ((iresp.data_ok !== 1'b1) || (iresp.data !== 32'hA5A5_0001)) begin
      n_fail++; $display("FAIL rst_recover got=%b/%h exp=1/a5a50001", iresp.data_ok, iresp.data);
    end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_ireq_only();
    @(negedge clk); ireq.valid = 1'b1; ireq.addr = 32'hBFC0_0000; #1;
    n_checks++; if ({iresp.addr_ok, dresp.addr_ok, mreq.valid} !== 3'b100) begin
      n_fail++; $display("FAIL ionly_c0 got=%b%b%b exp=100", iresp.addr_ok, dresp.addr_ok, mreq.valid);
    end
    @(negedge clk); ireq.valid = 1'b0; mresp.ready = 1'b1; #1;
    n_checks++; if ({mreq.valid, mreq.is_write, mreq.addr, mreq.size, mreq.strobe} !== {2'b10, 32'hBFC0_0000, 3'b010, 4'b0000}) begin
      n_fail++; $display("FAIL ionly_c1_mreq got=%h exp=v1 rd addr=bfc00000 size=2 strb=0", mreq);
    end
    n_checks++; if ({iresp.addr_ok, iresp.data_ok} !== 2'b00) begin n_fail++; $display("FAIL ionly_c1_resp got=%b%b exp=00", iresp.addr_ok, iresp.data_ok); end
    @(negedge clk); mresp.ready = 1'b0; mresp.last = 1'b1; mresp.data = 32'h3C08_0001; #1;
    n_checks++; if ((iresp.data_ok !== 1'b1) || (iresp.data !== 32'h3C08_0001) || (dresp.data_ok !== 1'b0) || (mreq.valid !== 1'b0)) begin
      n_fail++; $display("FAIL ionly_c2 got ok=%b data=%h dok=%b mv=%b exp 1 3c080001 0 0", iresp.data_ok, iresp.data, dresp.data_ok, mreq.valid);
    end
    @(negedge clk); idle_inputs(); #1;
    n_checks++; if ((iresp !== '0) || (dresp !== '0)) begin n_fail++; $display("FAIL ionly_c3 got=%h/%h exp=0", iresp, dresp); end
  endtask

  task automatic test_write();
    @(negedge clk);
    dreq.valid = 1'b1; dreq.addr = 32'h8000_1000; dreq.size = 3'b001; dreq.strobe = 4'b0011; dreq.data = 32'h0000_BEEF; #1;
    n_checks++; if ({dresp.addr_ok, iresp.addr_ok} !== 2'b10) begin n_fail++; $display("FAIL wr_grant got=%b%b exp=10", dresp.addr_ok, iresp.addr_ok); end
    @(negedge clk); dreq.valid = 1'b0; mresp.ready = 1'b1; #1;
    n_checks++; if (mreq !== {1'b1, 1'b1, 32'h8000_1000, 3'b001, 4'b0011, 32'h0000_BEEF}) begin
      n_fail++; $display("FAIL wr_mreq got=%h exp=write 80001000 sz1 strb3 0000beef", mreq);
    end
    @(negedge clk); mresp.ready = 1'b0; mresp.last = 1'b1; mresp.data = $urandom; #1;
    n_checks++; if ({dresp.data_ok, iresp.data_ok} !== 2'b10) begin n_fail++; $display("FAIL wr_data_ok got=%b%b exp=10", dresp.data_ok, iresp.data_ok); end
    @(negedge clk); idle_inputs(); #1;
    n_checks++; if (dresp.data_ok !== 1'b0) begin n_fail++; $display("FAIL wr_pulse_len got=%b exp=0", dresp.data_ok); end
  endtask

  task automatic test_contention();
    bus_src_e exp_src;
    logic [31:0] iaddr, daddr, rdata;
    resetn = 1'b0; idle_inputs();
    @(negedge clk); resetn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_src = ((k % 4) == 3) ? SRC_I : SRC_D;
      iaddr = 32'hBFC0_0000 + 32'(k * 4);
      daddr = 32'h8000_0000 + 32'(k * 4);
      @(negedge clk);
      ireq.valid = 1'b1; ireq.addr = iaddr;
      dreq.valid = 1'b1; dreq.addr = daddr; dreq.size = 3'b010; dreq.strobe = 4'b0000; dreq.data = '0;
      mresp = '0; #1;
      n_checks++; if ({iresp.addr_ok, dresp.addr_ok} !== ((exp_src == SRC_I) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL contend_order k=%0d got i/d=%b%b exp_src=%s", k, iresp.addr_ok, dresp.addr_ok, exp_src.name());
      end
      @(negedge clk); mresp.ready = 1'b1; #1;
      n_checks++; if (mreq.addr !== ((exp_src == SRC_I) ? iaddr : daddr)) begin
        n_fail++; $display("FAIL contend_addr k=%0d got=%h exp=%h", k, mreq.addr, (exp_src == SRC_I) ? iaddr : daddr);
      end
      rdata = $urandom;
      @(negedge clk); mresp.ready = 1'b0; mresp.last = 1'b1; mresp.data = rdata; #1;
      n_checks++; if ({iresp.data_ok, dresp.data_ok, iresp.addr_ok, dresp.addr_ok} !== ((exp_src == SRC_I) ? 4'b1000 : 4'b0100)) begin
        n_fail++; $display("FAIL contend_ret k=%0d got dok=%b%b aok=%b%b", k, iresp.data_ok, dresp.data_ok, iresp.addr_ok, dresp.addr_ok);
      end
    end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_backpressure();
    mem_req_t exp_m;
    @(negedge clk);
    dreq.valid = 1'b1; dreq.addr = 32'h8000_2000; dreq.size = 3'b010; dreq.strobe = 4'b1111; dreq.data = 32'hCAFE_F00D; #1;
    n_checks++; if (dresp.addr_ok !== 1'b1) begin n_fail++; $display("FAIL bp_grant got=%b exp=1", dresp.addr_ok); end
    exp_m = {1'b1, 1'b1, 32'h8000_2000, 3'b010, 4'b1111, 32'hCAFE_F00D};
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      dreq.addr = $urandom; dreq.data = $urandom; dreq.strobe = 4'($urandom);
      ireq.valid = 1'b1; ireq.addr = $urandom;
      mresp.ready = (c == 10); mresp.last = 1'b0; #1;
      n_checks++; if (mreq !== exp_m) begin n_fail++; $display("FAIL bp_mreq c=%0d got=%h exp=%h", c, mreq, exp_m); end
      n_checks++; if ({iresp.addr_ok, dresp.addr_ok, iresp.data_ok, dresp.data_ok} !== 4'b0000) begin
        n_fail++; $display("FAIL bp_resp c=%0d got=%b%b%b%b exp=0000", c, iresp.addr_ok, dresp.addr_ok, iresp.data_ok, dresp.data_ok);
      end
    end
    @(negedge clk); mresp.ready = 1'b0; mresp.last = 1'b1; mresp.data = $urandom; #1;
    n_checks++; if ({dresp.data_ok, iresp.addr_ok, dresp.addr_ok, mreq.valid} !== 4'b1000) begin
      n_fail++; $display("FAIL bp_done got dok=%b aok=%b%b mv=%b exp 1 00 0", dresp.data_ok, iresp.addr_ok, dresp.addr_ok, mreq.valid);
    end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_stray();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); mresp.ready = 1'b1; mresp.last = 1'b1; mresp.data = $urandom; #1;
      n_checks++; if ({iresp.data_ok, dresp.data_ok, mreq.valid, iresp.addr_ok, dresp.addr_ok} !== 5'b00000) begin
        n_fail++; $display("FAIL stray_idle c=%0d got=%b%b%b%b%b exp=00000", c, iresp.data_ok, dresp.data_ok, mreq.valid, iresp.addr_ok, dresp.addr_ok);
      end
    end
    @(negedge clk); mresp = '0; ireq.valid = 1'b1; ireq.addr = 32'h0000_1000; #1;
    @(negedge clk); ireq.valid = 1'b0; mresp.last = 1'b1; #1;
    n_checks++; if ({mreq.valid, iresp.data_ok} !== 2'b10) begin n_fail++; $display("FAIL stray_req got=%b%b exp=10", mreq.valid, iresp.data_ok); end
    @(negedge clk); mresp.last = 1'b0; mresp.ready = 1'b1; #1;
    n_checks++; if (mreq.valid !== 1'b1) begin n_fail++; $display("FAIL stray_req_hold got=%b exp=1", mreq.valid); end
    @(negedge clk); mresp.ready = 1'b1; #1;
    n_checks++; if ({mreq.valid, iresp.data_ok} !== 2'b00) begin n_fail++; $display("FAIL stray_wait_ready got=%b%b exp=00", mreq.valid, iresp.data_ok); end
    @(negedge clk); mresp.ready = 1'b0; mresp.last = 1'b1; mresp.data = 32'h0BAD_C0DE; #1;
    n_checks++; if ((iresp.data_ok !== 1'b1) || (iresp.data !== 32'h0BAD_C0DE)) begin
      n_fail++; $display("FAIL stray_finish got=%b/%h exp=1/0badc0de", iresp.data_ok, iresp.data);
    end
    @(negedge clk); idle_inputs();
  endtask

  // Masters hold a request until accepted; memory answers with random delays and stray strobes.
  task automatic test_random();
    bit        i_pend, d_pend, busy, any, drv_ready, drv_last;
    ibus_req_t ip;
    dbus_req_t dp;
    bus_src_e  src, win;
    int        phase, wait_n, losses;
    logic [31:0] mdata;
    logic [31:0] e_addr, e_data;
    logic [2:0]  e_size;
    logic [3:0]  e_strb;
    i_pend = 0; d_pend = 0; busy = 0; phase = 0; wait_n = 0; losses = 0;
    src = SRC_I; ip = '0; dp = '0;
    e_addr = '0; e_data = '0; e_size = '0; e_strb = '0;
    resetn = 1'b0; idle_inputs();
    @(negedge clk); resetn = 1'b1;
    for (int c = 0; c < 640; c++) begin
      @(negedge clk);
      if (!i_pend && (c < 580) && ($urandom_range(0, 2) != 0)) begin
        i_pend = 1; ip.valid = 1'b1; ip.addr = $urandom;
      end
      if (!d_pend && (c < 580) && ($urandom_range(0, 2) != 0)) begin
        d_pend = 1; dp.valid = 1'b1; dp.addr = $urandom; dp.size = 3'($urandom_range(0, 2));
        dp.strobe = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom); dp.data = $urandom;
      end
      ireq = i_pend ? ip : '{valid: 1'b0, addr: $urandom};
      dreq = d_pend ? dp : '0;
      mdata = $urandom;
      drv_ready = ($urandom_range(0, 3) == 0);
      drv_last  = ($urandom_range(0, 3) == 0);
      if (busy && (phase == 0)) drv_ready = (wait_n == 0);
      if (busy && (phase == 1)) drv_last = (wait_n == 0);
      mresp.ready = drv_ready; mresp.last = drv_last; mresp.data = mdata;
      #1;
      if (!busy) begin
        any = i_pend || d_pend;
        win = (d_pend && !(i_pend && (losses == int'(LIMIT)))) ? SRC_D : SRC_I;
        n_checks++; if ({iresp.addr_ok, dresp.addr_ok} !== {any && (win == SRC_I), any && (win == SRC_D)}) begin
          n_fail++; $display("FAIL rnd_grant c=%0d got i/d=%b%b exp=%b%b", c, iresp.addr_ok, dresp.addr_ok, any && (win == SRC_I), any && (win == SRC_D));
        end
        n_checks++; if ({iresp.data_ok, dresp.data_ok, mreq.valid} !== 3'b000) begin
          n_fail++; $display("FAIL rnd_idle c=%0d got=%b%b%b exp=000", c, iresp.data_ok, dresp.data_ok, mreq.valid);
        end
        if (any) begin
          if (win == SRC_D) begin
            if (i_pend && (losses < 3)) losses++;
            e_addr = dp.addr; e_size = dp.size; e_strb = dp.strobe; e_data = dp.data; d_pend = 0;
          end else begin
            losses = 0;
            e_addr = ip.addr; e_size = 3'b010; e_strb = 4'b0000; e_data = '0; i_pend = 0;
          end
          src = win; busy = 1; phase = 0; wait_n = $urandom_range(0, 3);
        end
      end else if (phase == 0) begin
        n_checks++; if ({mreq.valid, mreq.is_write, mreq.addr, mreq.size, mreq.strobe} !== {1'b1, (e_strb != 4'b0000), e_addr, e_size, e_strb}) begin
          n_fail++; $display("FAIL rnd_mreq c=%0d got=%h exp addr=%h size=%h strb=%h", c, mreq, e_addr, e_size, e_strb);
        end
        if (e_strb != 4'b0000) begin
          n_checks++; if (mreq.data !== e_data) begin n_fail++; $display("FAIL rnd_wdata c=%0d got=%h exp=%h", c, mreq.data, e_data); end
        end
        n_checks++; if ({iresp.addr_ok, dresp.addr_ok, iresp.data_ok, dresp.data_ok} !== 4'b0000) begin
          n_fail++; $display("FAIL rnd_req_resp c=%0d got=%b%b%b%b exp=0000", c, iresp.addr_ok, dresp.addr_ok, iresp.data_ok, dresp.data_ok);
        end
        if (drv_ready) begin phase = 1; wait_n = $urandom_range(0, 3); end
        else wait_n--;
      end else begin
        n_checks++; if ({mreq.valid, iresp.addr_ok, dresp.addr_ok} !== 3'b000) begin
          n_fail++; $display("FAIL rnd_wait c=%0d got=%b%b%b exp=000", c, mreq.valid, iresp.addr_ok, dresp.addr_ok);
        end
        n_checks++; if ({iresp.data_ok, dresp.data_ok} !== {drv_last && (src == SRC_I), drv_last && (src == SRC_D)}) begin
          n_fail++; $display("FAIL rnd_data_ok c=%0d got=%b%b exp=%b%b", c, iresp.data_ok, dresp.data_ok, drv_last && (src == SRC_I), drv_last && (src == SRC_D));
        end
        if (drv_last && (e_strb == 4'b0000)) begin
          n_checks++; if (((src == SRC_I) ? iresp.data : dresp.data) !== mdata) begin
            n_fail++; $display("FAIL rnd_rdata c=%0d got=%h exp=%h", c, (src == SRC_I) ? iresp.data : dresp.data, mdata);
          end
        end
        if (drv_last) busy = 0;
        else wait_n--;
      end
    end
    n_checks++; if (busy || i_pend || d_pend) begin
      n_fail++; $display("FAIL rnd_drain got busy=%b ipend=%b dpend=%b exp=000", busy, i_pend, d_pend);
    end
    @(negedge clk); idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    resetn = 1'b0;
    test_reset();
    test_ireq_only();
    test_write();
    test_contention();
    test_backpressure();
    test_stray();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
